// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display path.
package seg_pkg;

    // Bit positions of each segment within a 7-bit digit pattern.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Pattern driven while blanking, before polarity is applied.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Phase within a digit slot.
    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/slot_timer.sv
// Digit-slot prescaler: counts PRESCALE cycles per slot and flags the
// leading blanking window, the first cycle and the last cycle of each slot.
module slot_timer #(
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    output logic in_blank,
    output logic slot_start,
    output logic slot_end
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST      = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] slot_cnt;

    // Free-running slot counter, wrapping at the end of every slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         slot_cnt <= '0;
        else if (slot_end) slot_cnt <= '0;
        else               slot_cnt <= slot_cnt + CW'(1);
    end

    assign slot_end   = (slot_cnt == LAST);
    assign slot_start = (slot_cnt == '0);
    assign in_blank   = (BLANK_CYCLES > 0) && (slot_cnt < BLANK_END);

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment driver. Scans digits from the highest index
// down to 0, blanks at the start of each slot, and swaps in a new frame only
// at the frame boundary via a sticky request / one-cycle acknowledge.
module seven_segment_scanner
    import seg_pkg::*;
#(
    parameter int DISPLAY_WIDTH = 12,
    parameter int PRESCALE      = 1000,
    parameter int BLANK_CYCLES  = 16,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DISPLAY_WIDTH-1:0][6:0] seven_segment_array,
    input  logic                          update_req,
    output logic                          update_ack,
    output logic                          frame_done,
    output logic [DISPLAY_WIDTH-1:0]      digit_enable,
    output logic [6:0]                    segments
);

    localparam int IW = (DISPLAY_WIDTH > 1) ? $clog2(DISPLAY_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DISPLAY_WIDTH - 1);

    // XOR masks that apply output polarity; also the inactive output levels.
    localparam logic [DISPLAY_WIDTH-1:0] EN_POL  = {DISPLAY_WIDTH{ACTIVE_LOW}};
    localparam logic [6:0]               SEG_POL = {7{ACTIVE_LOW}};

    logic                          in_blank;
    logic                          slot_start;
    logic                          slot_end;
    scan_state_t                   state;
    logic [IW-1:0]                 idx;
    logic [DISPLAY_WIDTH-1:0][6:0] shadow;
    logic [DISPLAY_WIDTH-1:0][6:0] shadow_d;
    logic                          pending;
    logic                          boundary;
    logic                          capture;
    logic [DISPLAY_WIDTH-1:0]      en_d;
    logic [6:0]                    seg_d;

    slot_timer #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .in_blank   (in_blank),
        .slot_start (slot_start),
        .slot_end   (slot_end)
    );

    assign state = in_blank ? BLANK : DRIVE;

    // The first cycle of the top digit's slot is the cycle right after the
    // wrap from digit 0. The reset state is that same point, so the first
    // cycle after release is a boundary too.
    assign boundary = slot_start && (idx == LAST_IDX);
    assign capture  = boundary && (pending || update_req);

    // Digit index steps down once per slot and wraps to the top digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         idx <= LAST_IDX;
        else if (slot_end) idx <= (idx == '0) ? LAST_IDX : idx - IW'(1);
    end

    // Next shadow value; outputs use it so a freshly captured frame is
    // shown from its first driven cycle, even with blanking disabled.
    always_comb begin
        shadow_d = shadow;
        if (capture) shadow_d = seven_segment_array;
    end

    // Request/ack handshake and frame capture. A request seen while the ack
    // is high belongs to the request just served and is not re-armed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= 1'b0;
            shadow     <= '0;
            update_ack <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pending    <= !capture && (pending || (update_req && !update_ack));
            shadow     <= shadow_d;
            update_ack <= capture;
            frame_done <= boundary;
        end
    end

    // Logical (active-high) digit enable and segment pattern for this cycle.
    always_comb begin
        en_d  = '0;
        seg_d = SEG_BLANK;
        if (state == DRIVE) begin
            en_d[idx] = 1'b1;
            seg_d     = shadow_d[idx];
        end
    end

    // Output register; polarity is applied here, last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_enable <= EN_POL;
            segments     <= SEG_POL;
        end else begin
            digit_enable <= en_d ^ EN_POL;
            segments     <= seg_d ^ SEG_POL;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: an active-low and an active-high build
// share stimulus; a position-based reference model pushes expected outputs
// per cycle and each scenario pops and compares them after the clock edge.
module tb_seven_segment_scanner;

    localparam int W = 4;
    localparam int P = 8;
    localparam int B = 2;

    localparam logic [W-1:0][6:0] F1 = {7'h7E, 7'h30, 7'h6D, 7'h79};
    localparam logic [W-1:0][6:0] F2 = {7'h33, 7'h5B, 7'h5F, 7'h70};
    localparam logic [W-1:0][6:0] F3 = {7'h7F, 7'h7B, 7'h77, 7'h1F};

    typedef logic [25:0] vec_t;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                update_req = 1'b0;
    logic [W-1:0][6:0]   arr = '0;
    logic                ack0, fd0, ack1, fd1;
    logic [W-1:0]        en0, en1;
    logic [6:0]          seg0, seg1;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t exp_q[$];

    // Reference model state: position since reset release, pending, shadow.
    int                m_t = 0;
    bit                m_pend = 1'b0;
    bit                m_pack = 1'b0;
    logic [W-1:0][6:0] m_shadow = '0;

    seven_segment_scanner #(
        .DISPLAY_WIDTH (W), .PRESCALE (P), .BLANK_CYCLES (B), .ACTIVE_LOW (1'b1)
    ) u_dut_lo (
        .clk (clk), .reset (reset), .seven_segment_array (arr),
        .update_req (update_req), .update_ack (ack0), .frame_done (fd0),
        .digit_enable (en0), .segments (seg0)
    );

    seven_segment_scanner #(
        .DISPLAY_WIDTH (W), .PRESCALE (P), .BLANK_CYCLES (B), .ACTIVE_LOW (1'b0)
    ) u_dut_hi (
        .clk (clk), .reset (reset), .seven_segment_array (arr),
        .update_req (update_req), .update_ack (ack1), .frame_done (fd1),
        .digit_enable (en1), .segments (seg1)
    );

    always #5 clk = ~clk;

    function automatic vec_t obs();
        return {ack0, fd0, en0, seg0, ack1, fd1, en1, seg1};
    endfunction

    // Expected outputs after the coming edge, from the current inputs.
    task automatic model_push();
        logic [W-1:0]      en;
        logic [6:0]        seg;
        logic [W-1:0][6:0] nsh;
        bit                ack, fd;
        int                p, dig, slot;
        en = '0; seg = '0; ack = 1'b0; fd = 1'b0;
        if (reset) begin
            m_t = 0; m_pend = 1'b0; m_pack = 1'b0; m_shadow = '0;
        end else begin
            p    = m_t % (W * P);
            dig  = (W - 1) - p / P;
            slot = p % P;
            fd   = (p == 0);
            ack  = fd && (m_pend || update_req);
            nsh  = ack ? arr : m_shadow;
            if (slot >= B) begin
                en[dig] = 1'b1;
                seg     = nsh[dig];
            end
            m_pend   = !ack && (m_pend || (update_req && !m_pack));
            m_pack   = ack;
            m_shadow = nsh;
            m_t++;
        end
        exp_q.push_back({ack, fd, ~en, ~seg, ack, fd, en, seg});
    endtask

    task automatic tick();
        model_push();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t e;
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (obs() !== {2'b00, 4'hF, 7'h7F, 2'b00, 4'h0, 7'h00}) begin
            n_fail++;
            $display("FAIL reset_async got %h exp %h", obs(), {2'b00, 4'hF, 7'h7F, 2'b00, 4'h0, 7'h00});
        end
        for (int c = 0; c < 70; c++) begin
            if (c == 3) reset = 1'b0;
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL reset_idle t=%0t got %h exp %h", $time, obs(), e);
            end
        end
    endtask

    task automatic test_capture();
        vec_t e;
        int   acks = 0;
        for (int c = 0; c < 80; c++) begin
            update_req = (c == 4);
            if (c == 4) arr = F1;
            tick();
            if (ack0) acks++;
            e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL capture t=%0t got %h exp %h", $time, obs(), e);
            end
        end
        n_tests++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL capture_ack_count got %0d exp 1", acks);
        end
    endtask

    task automatic test_boundary_req();
        vec_t e;
        int   k = -1;
        int   acks = 0;
        for (int c = 0; c < 80; c++) begin
            if (k < 0 && (m_t % (W * P)) == 0) k = 0;
            update_req = (k == 0 || k == 1);
            if (k == 0) arr = F2;
            if (k >= 0) k++;
            tick();
            if (ack0) acks++;
            e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL boundary_req t=%0t got %h exp %h", $time, obs(), e);
            end
        end
        update_req = 1'b0;
        n_tests++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL boundary_ack_count got %0d exp 1", acks);
        end
    endtask

    task automatic test_late_change();
        vec_t e;
        bit   sent = 1'b0;
        for (int c = 0; c < 80; c++) begin
            update_req = 1'b0;
            if (!sent && (m_t % (W * P)) == 10) begin
                update_req = 1'b1;
                arr        = F3;
                sent       = 1'b1;
            end
            if (sent && (m_t % (W * P)) == 14) arr = '0;
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL late_change t=%0t got %h exp %h", $time, obs(), e);
            end
        end
    endtask

    task automatic test_reset_mid_drive();
        vec_t e;
        bit   sent = 1'b0;
        int   acks = 0;
        for (int c = 0; c < 64 && !(sent && (m_t % (W * P)) == 20); c++) begin
            update_req = 1'b0;
            if (!sent && (m_t % (W * P)) == 5) begin
                update_req = 1'b1;
                arr        = F1;
                sent       = 1'b1;
            end
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL mid_drive_pre t=%0t got %h exp %h", $time, obs(), e);
            end
        end
        update_req = 1'b0;
        reset = 1'b1;
        #1;
        n_tests++;
        if (obs() !== {2'b00, 4'hF, 7'h7F, 2'b00, 4'h0, 7'h00}) begin
            n_fail++;
            $display("FAIL mid_drive_async got %h exp %h", obs(), {2'b00, 4'hF, 7'h7F, 2'b00, 4'h0, 7'h00});
        end
        for (int c = 0; c < 42; c++) begin
            if (c == 2) reset = 1'b0;
            tick();
            if (ack0) acks++;
            e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL mid_drive_post t=%0t got %h exp %h", $time, obs(), e);
            end
        end
        n_tests++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL mid_drive_discard got %0d acks exp 0", acks);
        end
    endtask

    task automatic test_req_across_reset();
        vec_t e;
        for (int c = 0; c < 45; c++) begin
            reset      = (c < 2);
            update_req = (c < 3);
            arr        = F2;
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL req_across_reset t=%0t got %h exp %h", $time, obs(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_boundary_req();
        test_late_change();
        test_reset_mid_drive();
        test_req_across_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
